// File: rtl/crop_job_controller.sv
// crop_job_controller: queues crop jobs, validates and clamps their windows, runs them on the crop engine and reports status
module crop_job_controller #(
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int QDEPTH      = 2,
  parameter int TIMEOUT     = 2000000,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [3:0]  job_id,
  input  logic [10:0] job_xmin,
  input  logic [10:0] job_xmax,
  input  logic [10:0] job_ymin,
  input  logic [10:0] job_ymax,
  output logic        eng_start,
  input  logic        eng_done,
  output logic        eng_rst_n,
  output logic [10:0] eng_xmin,
  output logic [10:0] eng_xmax,
  output logic [10:0] eng_ymin,
  output logic [10:0] eng_ymax,
  output logic        stat_valid,
  output logic [3:0]  stat_id,
  output logic [1:0]  stat_code,
  output logic        busy
);
  localparam int AW = $clog2(QDEPTH);
  localparam int RW = $clog2(RECOVER_CYC) + 1;
  localparam logic [10:0] XLIM = 11'(WIDTH - 1);
  localparam logic [10:0] YLIM = 11'(HEIGHT - 1);
  typedef struct packed {
    logic [10:0] xmin, xmax, ymin, ymax;
  } win_t;
  typedef struct packed {
    logic [3:0] id;
    win_t       w;
  } job_t;
  typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT_LOW, RUN, REPORT, RECOVER} state_t;
  job_t          mem_q [QDEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          job_ready_q, job_ready_d;
  job_t          job_q, job_d;
  win_t          eng_q, eng_d;
  logic [1:0]    code_q, code_d;
  logic          eng_start_q, eng_start_d;
  logic          eng_rst_n_q, eng_rst_n_d;
  logic          stat_valid_q, stat_valid_d;
  logic [3:0]    stat_id_q, stat_id_d;
  logic [1:0]    stat_code_q, stat_code_d;
  logic [31:0]   tmo_q, tmo_d;
  logic [RW-1:0] rc_q, rc_d;
  logic          push, pop, rej, cx, cy, tmo_hit;
  assign push    = job_valid && job_ready_q;
  assign pop     = state_q == IDLE && fill_q != '0;
  assign rej     = job_q.w.xmin > job_q.w.xmax || job_q.w.ymin > job_q.w.ymax ||
                   job_q.w.xmin > XLIM || job_q.w.ymin > YLIM;
  assign cx      = job_q.w.xmax > XLIM;
  assign cy      = job_q.w.ymax > YLIM;
  assign tmo_hit = tmo_q + 32'd1 >= 32'(TIMEOUT);
  // Next-state: FIFO bookkeeping, job sequencing, and outputs derived from the state being entered
  always_comb begin
    wptr_d      = wptr_q + AW'(push);
    rptr_d      = rptr_q + AW'(pop);
    fill_d      = fill_q + (AW + 1)'(push) - (AW + 1)'(pop);
    job_ready_d = fill_d != (AW + 1)'(QDEPTH);
    state_d     = state_q;
    job_d       = job_q;
    eng_d       = eng_q;
    code_d      = code_q;
    tmo_d       = tmo_q;
    rc_d        = rc_q;
    case (state_q)
      IDLE: if (pop) begin
        job_d   = mem_q[rptr_q];
        state_d = CHECK;
      end
      CHECK: if (rej) begin
        code_d  = 2'd2;
        state_d = REPORT;
      end else begin
        eng_d.xmin = job_q.w.xmin;
        eng_d.xmax = cx ? XLIM : job_q.w.xmax;
        eng_d.ymin = job_q.w.ymin;
        eng_d.ymax = cy ? YLIM : job_q.w.ymax;
        code_d     = {1'b0, cx || cy};
        state_d    = LAUNCH;
      end
      LAUNCH: begin
        tmo_d   = 32'd1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW, RUN: begin
        tmo_d = tmo_q + 32'd1;
        if (state_q == RUN && eng_done) state_d = REPORT;
        else if (tmo_hit) begin
          code_d  = 2'd3;
          rc_d    = '0;
          state_d = RECOVER;
        end else if (state_q == WAIT_LOW && !eng_done) state_d = RUN;
      end
      RECOVER: if (rc_q == RW'(RECOVER_CYC - 1)) state_d = REPORT;
               else rc_d = rc_q + RW'(1);
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    eng_start_d  = state_d == LAUNCH;
    eng_rst_n_d  = state_d != RECOVER;
    stat_valid_d = state_d == REPORT;
    stat_id_d    = stat_valid_d ? job_q.id : stat_id_q;
    stat_code_d  = stat_valid_d ? code_d : stat_code_q;
  end
  // State and registered outputs; reset flushes the FIFO and holds the engine in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fill_q       <= '0;
      job_ready_q  <= 1'b0;
      job_q        <= '0;
      eng_q        <= '0;
      code_q       <= '0;
      eng_start_q  <= 1'b0;
      eng_rst_n_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_id_q    <= '0;
      stat_code_q  <= '0;
      tmo_q        <= '0;
      rc_q         <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fill_q       <= fill_d;
      job_ready_q  <= job_ready_d;
      job_q        <= job_d;
      eng_q        <= eng_d;
      code_q       <= code_d;
      eng_start_q  <= eng_start_d;
      eng_rst_n_q  <= eng_rst_n_d;
      stat_valid_q <= stat_valid_d;
      stat_id_q    <= stat_id_d;
      stat_code_q  <= stat_code_d;
      tmo_q        <= tmo_d;
      rc_q         <= rc_d;
    end
  end
  // FIFO storage; stale entries are harmless since the pointers define contents
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= {job_id, job_xmin, job_xmax, job_ymin, job_ymax};
  end
  assign job_ready  = job_ready_q;
  assign eng_start  = eng_start_q;
  assign eng_rst_n  = eng_rst_n_q;
  assign eng_xmin   = eng_q.xmin;
  assign eng_xmax   = eng_q.xmax;
  assign eng_ymin   = eng_q.ymin;
  assign eng_ymax   = eng_q.ymax;
  assign stat_valid = stat_valid_q;
  assign stat_id    = stat_id_q;
  assign stat_code  = stat_code_q;
  assign busy       = fill_q != '0 || state_q != IDLE;
endmodule

// File: tb/tb_crop_job_controller.sv
// tb_crop_job_controller: directed jobs against an engine model, with a spec-level job/status scoreboard
module tb_crop_job_controller;
  localparam int W = 100, H = 100;
  typedef struct packed { logic [10:0] xmin, xmax, ymin, ymax; } win_t;
  typedef struct packed { logic [3:0] id; logic [1:0] code; } st_t;
  logic clk = 1'b0, rst = 1'b1, job_valid = 1'b0, eng_done = 1'b1;
  logic [3:0] job_id = '0;
  logic [10:0] job_xmin = '0, job_xmax = '0, job_ymin = '0, job_ymax = '0;
  logic job_ready, eng_start, eng_rst_n, stat_valid, busy;
  logic [10:0] eng_xmin, eng_xmax, eng_ymin, eng_ymax;
  logic [3:0] stat_id;
  logic [1:0] stat_code;
  crop_job_controller #(.WIDTH(W), .HEIGHT(H), .QDEPTH(2), .TIMEOUT(1000), .RECOVER_CYC(2)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_xmin(job_xmin), .job_xmax(job_xmax), .job_ymin(job_ymin), .job_ymax(job_ymax),
    .eng_start(eng_start), .eng_done(eng_done), .eng_rst_n(eng_rst_n),
    .eng_xmin(eng_xmin), .eng_xmax(eng_xmax), .eng_ymin(eng_ymin), .eng_ymax(eng_ymax),
    .stat_valid(stat_valid), .stat_id(stat_id), .stat_code(stat_code), .busy(busy));
  int checks = 0, errors = 0, cyc = 0;
  win_t exp_launch[$];
  st_t exp_stat[$];
  win_t model_win = '0;
  int outstanding = 0, start_n = 0, stat_n = 0, last_start = 0, low_total = 0, low_first = 0;
  int starts[$], stat_cycs[$];
  logic [3:0] stat_ids[$];
  logic [1:0] stat_codes[$];
  logic rst_prev = 1'b0, rstn_prev = 1'b1, act_e = 1'b0;
  int t_e = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Engine: done drops the cycle after start, rises 500 cycles later; windows starting at x=77 hang
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      eng_done <= 1'b1;
      act_e <= 1'b0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      act_e <= 1'b1;
      t_e <= 1;
    end else if (act_e) begin
      t_e <= t_e + 1;
      if (t_e == 500 && eng_xmin != 11'd77) begin
        eng_done <= 1'b1;
        act_e <= 1'b0;
      end
    end
  end
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic void model_push(logic [3:0] id, logic [10:0] x0, x1, y0, y1);
    logic cx, cy;
    win_t w;
    if (x0 > x1 || y0 > y1 || x0 >= W || y0 >= H) exp_stat.push_back('{id, 2'd2});
    else begin
      cx = x1 > W - 1;
      cy = y1 > H - 1;
      w = '{x0, cx ? 11'(W - 1) : x1, y0, cy ? 11'(H - 1) : y1};
      exp_launch.push_back(w);
      exp_stat.push_back('{id, x0 == 11'd77 ? 2'd3 : {1'b0, cx | cy}});
    end
  endfunction
  // Every-cycle compare against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev)
        chk("reset_outputs", {job_ready, eng_start, eng_rst_n, stat_valid, busy, stat_id, stat_code,
                              eng_xmin, eng_xmax, eng_ymin, eng_ymax}, '0);
      exp_launch.delete();
      exp_stat.delete();
      outstanding = 0;
      model_win = '0;
    end else begin
      chk("busy", busy, outstanding > 0);
      if (eng_start) begin
        start_n++;
        starts.push_back(cyc);
        last_start = cyc;
        if (exp_launch.size() == 0) begin
          checks++; errors++;
          $display("FAIL launch got=start exp=no_start");
        end else model_win = exp_launch.pop_front();
      end
      chk("eng_window", {eng_xmin, eng_xmax, eng_ymin, eng_ymax}, model_win);
      if (stat_valid) begin
        stat_n++;
        stat_cycs.push_back(cyc);
        stat_ids.push_back(stat_id);
        stat_codes.push_back(stat_code);
        outstanding--;
        if (exp_stat.size() == 0) begin
          checks++; errors++;
          $display("FAIL status got=%0d/%0d exp=none", stat_id, stat_code);
        end else chk("status", {stat_id, stat_code}, exp_stat.pop_front());
      end
      if (!eng_rst_n) begin
        if (rstn_prev) low_first = cyc;
        low_total++;
      end
      if (job_valid && job_ready) begin
        model_push(job_id, job_xmin, job_xmax, job_ymin, job_ymax);
        outstanding++;
      end
    end
    rst_prev = rst;
    rstn_prev = eng_rst_n;
  end
  task automatic ncyc();
    @(negedge clk); #1;
  endtask
  task automatic drive_edge();
    @(posedge clk); #1;
  endtask
  task automatic push_job(input logic [3:0] id, input logic [10:0] x0, x1, y0, y1, output int t);
    int k = 0;
    job_valid = 1'b1; job_id = id;
    job_xmin = x0; job_xmax = x1; job_ymin = y0; job_ymax = y1;
    do begin ncyc(); k++; end while (!job_ready && k < 3000);
    chk("push_accepted", job_ready, 1'b1);
    t = cyc;
    drive_edge();
    job_valid = 1'b0;
  endtask
  task automatic wait_stat(input int n, input int limit);
    int k = 0;
    while (stat_n < n && k < limit) begin ncyc(); k++; end
    chk("status_arrives", stat_n >= n, 1'b1);
  endtask
  task automatic wait_until_cyc(input int target);
    while (cyc < target) ncyc();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int t, t2, sn0, st0, low0, s, k;
    repeat (3) drive_edge();
    rst = 1'b0;
    drive_edge();
    ncyc();
    chk("post_reset_ready_rstn", {job_ready, eng_rst_n}, 2'b11);
    // 1: plain job
    sn0 = stat_n;
    drive_edge();
    push_job(4'd3, 11'd10, 11'd20, 11'd5, 11'd15, t);
    wait_stat(sn0 + 1, 700);
    chk("t1_start_latency", last_start - t, 3);
    chk("t1_window", {eng_xmin, eng_xmax, eng_ymin, eng_ymax}, {11'd10, 11'd20, 11'd5, 11'd15});
    chk("t1_status", {stat_ids[sn0], stat_codes[sn0]}, {4'd3, 2'd0});
    chk("t1_done_latency", stat_cycs[sn0] - t, 505);
    wait_until_cyc(stat_cycs[sn0] + 1);
    chk("t1_busy_after", busy, 1'b0);
    // 2: clamped job
    sn0 = stat_n;
    drive_edge();
    push_job(4'd1, 11'd90, 11'd150, 11'd0, 11'd120, t);
    wait_stat(sn0 + 1, 700);
    chk("t2_window", {eng_xmin, eng_xmax, eng_ymin, eng_ymax}, {11'd90, 11'd99, 11'd0, 11'd99});
    chk("t2_status", {stat_ids[sn0], stat_codes[sn0]}, {4'd1, 2'd1});
    // 3: two rejected jobs back to back
    sn0 = stat_n; st0 = start_n;
    drive_edge();
    push_job(4'd2, 11'd30, 11'd20, 11'd0, 11'd10, t);
    push_job(4'd4, 11'd100, 11'd100, 11'd0, 11'd0, t2);
    wait_stat(sn0 + 2, 50);
    chk("t3_no_start", start_n - st0, 0);
    chk("t3_window_hold", {eng_xmin, eng_xmax, eng_ymin, eng_ymax}, {11'd90, 11'd99, 11'd0, 11'd99});
    chk("t3_status", {stat_ids[sn0], stat_codes[sn0], stat_ids[sn0 + 1], stat_codes[sn0 + 1]},
        {4'd2, 2'd2, 4'd4, 2'd2});
    chk("t3_reject_latency", stat_cycs[sn0] - t, 3);
    chk("t3_second_latency", stat_cycs[sn0 + 1] - t, 6);
    // 4: three back-to-back jobs fill the FIFO
    sn0 = stat_n;
    drive_edge();
    push_job(4'd5, 11'd1, 11'd2, 11'd3, 11'd4, t);
    push_job(4'd6, 11'd0, 11'd99, 11'd0, 11'd99, t);
    push_job(4'd7, 11'd50, 11'd60, 11'd70, 11'd80, t);
    chk("t4_full", job_ready, 1'b0);
    wait_stat(sn0 + 3, 2000);
    chk("t4_order", {stat_ids[sn0], stat_ids[sn0 + 1], stat_ids[sn0 + 2]}, {4'd5, 4'd6, 4'd7});
    // 5: hung engine, then the queued job runs
    sn0 = stat_n; st0 = start_n; low0 = low_total;
    drive_edge();
    push_job(4'd9, 11'd77, 11'd80, 11'd1, 11'd2, t);
    push_job(4'd10, 11'd4, 11'd5, 11'd6, 11'd7, t2);
    wait_stat(sn0 + 1, 1200);
    s = starts[st0];
    chk("t5_recover_start", low_first - s, 1000);
    chk("t5_recover_len", low_total - low0, 2);
    chk("t5_status", {stat_ids[sn0], stat_codes[sn0]}, {4'd9, 2'd3});
    chk("t5_report_cyc", stat_cycs[sn0] - s, 1002);
    wait_stat(sn0 + 2, 700);
    chk("t5_next_launch", starts[st0 + 1] - s, 1005);
    chk("t5_next_status", {stat_ids[sn0 + 1], stat_codes[sn0 + 1]}, {4'd10, 2'd0});
    // 6: reset during RUN with a job queued
    sn0 = stat_n; st0 = start_n;
    drive_edge();
    push_job(4'd11, 11'd1, 11'd2, 11'd3, 11'd4, t);
    push_job(4'd12, 11'd5, 11'd6, 11'd7, 11'd8, t);
    k = 0;
    while (start_n == st0 && k < 20) begin ncyc(); k++; end
    repeat (20) ncyc();
    drive_edge();
    rst = 1'b1;
    drive_edge();
    ncyc();
    chk("t6_in_reset", {job_ready, eng_rst_n, busy, stat_valid}, 4'b0);
    drive_edge();
    rst = 1'b0;
    drive_edge();
    ncyc();
    chk("t6_post_reset", {job_ready, eng_rst_n}, 2'b11);
    repeat (30) ncyc();
    chk("t6_no_status", stat_n - sn0, 0);
    chk("t6_no_relaunch", start_n - st0, 1);
    chk("t6_idle", busy, 1'b0);
    drive_edge();
    push_job(4'd13, 11'd10, 11'd20, 11'd5, 11'd15, t);
    wait_stat(sn0 + 1, 700);
    chk("t6_resume", {stat_ids[sn0], stat_codes[sn0]}, {4'd13, 2'd0});
    chk("t6_resume_latency", last_start - t, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crop_job_controller.md
Name: crop_job_controller

Overview:
- Sequences crop jobs onto the single crop engine: queues host job requests, validates and clamps each crop window, pulses the engine start and watches its done level.
- Reports per-job status and recovers the engine on a hang.
- Sits between the host/control logic and the crop engine's start/done/window inputs; the engine's memory ports are untouched.

Parameters:
WIDTH, 100, source image width in pixels
HEIGHT, 100, source image height in pixels
QDEPTH, 2, job FIFO depth (power of two, >=2)
TIMEOUT, 2000000, max cycles from start pulse to done before abort
RECOVER_CYC, 2, cycles eng_rst_n is held low on abort

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
job_valid  in  1  host offers a job
job_ready  out  1  FIFO can accept
job_id  in  4  host tag, echoed in status
job_xmin, job_xmax, job_ymin, job_ymax  in  11 each  requested window, inclusive
eng_start  out  1  one-cycle start pulse to engine
eng_done  in  1  engine done level (high while idle/finished, low while running)
eng_rst_n  out  1  active-low engine reset
eng_xmin, eng_xmax, eng_ymin, eng_ymax  out  11 each  window driven to engine
stat_valid  out  1  one-cycle status pulse
stat_id  out  4  tag of reported job
stat_code  out  2  0 OK, 1 OK-clamped, 2 rejected, 3 timeout
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values while rst=1: FIFO flushed, FSM=IDLE, job_ready=0, eng_start=0, eng_rst_n=0, eng_* windows=0, stat_valid=0, stat_id=0, stat_code=0, busy=0, timeout counter=0.
- First cycle after rst deasserts: job_ready=1, eng_rst_n=1.
- Reset mid-job aborts silently: no status pulse.
- FIFO: push on job_valid&&job_ready. job_ready=!full, registered; it stays low when full even if a pop happens that cycle. Push and pop in the same cycle are legal when not full. Pointers wrap mod QDEPTH. Each entry holds {id, xmin, xmax, ymin, ymax}.
- FSM states: IDLE, CHECK, LAUNCH, WAIT_LOW, RUN, REPORT, RECOVER.
- IDLE: if FIFO non-empty, pop the head into job registers and go to CHECK.
- CHECK (1 cycle):
  - Reject if xmin>xmax, ymin>ymax, xmin>=WIDTH or ymin>=HEIGHT: set code=2, go to REPORT; engine window and eng_start untouched.
  - Otherwise clamp xmax to min(xmax, WIDTH-1) and ymax to min(ymax, HEIGHT-1). Code=1 if either was clamped, else 0.
  - Load eng_* registers and go to LAUNCH.
- LAUNCH (1 cycle): eng_start=1, timeout counter cleared to 1, go to WAIT_LOW.
- WAIT_LOW: wait for eng_done==0, then go to RUN. This handles done left high from the previous job.
- RUN: on eng_done==1 go to REPORT.
- Timeout: counter increments every cycle in WAIT_LOW/RUN. When it reaches TIMEOUT: code=3, go to RECOVER.
- RECOVER: eng_rst_n=0 for RECOVER_CYC cycles, then go to REPORT.
- REPORT (1 cycle): stat_valid=1 with the stored stat_id/stat_code, go to IDLE. No status backpressure.
- eng_* windows change only in CHECK and otherwise hold stable; they are not cleared after the job.
- Latency: with an empty FIFO and IDLE, a job accepted at cycle T gives CHECK at T+2 and eng_start high at T+3. A rejected job gives stat_valid at T+3.
- Jobs run strictly in FIFO order, one at a time. The counter is 32-bit unsigned; windows are unsigned 11-bit compares.

Test Plan:
1. Reset, then job id=3 window (10,20,5,15); engine model drops done 1 cycle after start and raises it 500 cycles later -> eng_start at T+3, eng_* = 10/20/5/15, stat_valid with id=3 code=0, busy falls the cycle after.
2. Job id=1 window (90,150,0,120), WIDTH=HEIGHT=100 -> eng_xmax=99, eng_ymax=99, code=1.
3. Jobs (30,20,0,10) and (100,100,0,0) -> no eng_start; two status pulses with code=2; eng_* retain their prior values.
4. Three back-to-back jobs with QDEPTH=2 while the engine is busy -> job_ready low once two are queued; jobs complete in id order 5,6,7 and none is lost.
5. Engine never raises done, TIMEOUT=1000 -> eng_rst_n low for exactly 2 cycles starting at cycle 1000 after start, then status code=3, then the next queued job launches.
6. rst asserted during RUN with one job queued -> no status pulse; FIFO empty, eng_rst_n=0, job_ready=0 during reset; normal operation resumes after.
